// File: rtl/operand_capture_8b_pkg.sv
// Shared types for the operand capture stage: data width and the buffered
// entry record produced by the +carry adder.
package operand_capture_8b_pkg;

  localparam int WIDTH = 8;

  // Field order fixes the packed layout; total width is WIDTH + 4.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             inverted;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic entry_t make_entry(input logic [WIDTH-1:0] data,
                                        input logic             carry_in,
                                        input logic             invert_tag);
    logic [WIDTH:0] sum;
    entry_t         e;
    sum        = {1'b0, data} + {{WIDTH{1'b0}}, carry_in};
    e.result   = sum[WIDTH-1:0];
    e.carry    = sum[WIDTH];
    e.zero     = (sum[WIDTH-1:0] == '0);
    e.negative = sum[WIDTH-1];
    e.inverted = invert_tag;
    return e;
  endfunction

endpackage

// File: rtl/operand_capture_8b_buffer.sv
// Generic DEPTH-entry circular buffer. Occupancy (level_o) is the state:
// 0 = empty, DEPTH = full, anything between = partially filled.
module operand_capture_buffer #(
  parameter  int W     = 12,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [PTR_W:0]   level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (level_q == '0);

  // Guard here too so a misbehaving parent can never overrun or underrun.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/operand_capture_8b.sv
// Captures inverter output plus carry-in, completes the +1, and buffers
// result/flag entries for the downstream ALU stage.
module operand_capture_8b
  import operand_capture_8b_pkg::*;
#(
  parameter  int WIDTH = operand_capture_8b_pkg::WIDTH,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             input_clock,
  input  logic             input_reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_invert,
  input  logic             input_carry,
  input  logic             input_valid,
  output logic             output_ready,
  output logic [WIDTH-1:0] output_result,
  output logic             output_carry,
  output logic             output_zero,
  output logic             output_negative,
  output logic             output_inverted,
  output logic             output_valid,
  input  logic             input_ready,
  output logic [PTR_W:0]   output_level
);

  // Handshake: a beat moves on a rising edge when valid && ready are both
  // high on that side; ready/valid here decode only from the stored level.
  entry_t push_entry;
  entry_t head_entry;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  assign push_entry = make_entry(input_data, input_carry, input_invert);

  assign output_ready = !full;
  assign output_valid = !empty;
  assign push         = input_valid && output_ready;
  assign pop          = output_valid && input_ready;

  operand_capture_buffer #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk_i   (input_clock),
    .rst_i   (input_reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .level_o (output_level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Popped slots keep stale data, so the head is masked while empty.
  always_comb begin
    output_result   = '0;
    output_carry    = 1'b0;
    output_zero     = 1'b0;
    output_negative = 1'b0;
    output_inverted = 1'b0;
    if (output_valid) begin
      output_result   = head_entry.result;
      output_carry    = head_entry.carry;
      output_zero     = head_entry.zero;
      output_negative = head_entry.negative;
      output_inverted = head_entry.inverted;
    end
  end

endmodule

// File: tb/tb_operand_capture_8b.sv
// Directed bench for operand_capture_8b: reset, negate, wrap/zero,
// back-pressure, full-with-pop, streaming and mid-stream reset.
module tb_operand_capture_8b;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_invert;
  logic       in_carry;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_negative;
  logic       out_inverted;
  logic       out_valid;
  logic       in_ready;
  logic [1:0] out_level;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];

  operand_capture_8b dut (
    .input_clock     (clk),
    .input_reset     (rst),
    .input_data      (in_data),
    .input_invert    (in_invert),
    .input_carry     (in_carry),
    .input_valid     (in_valid),
    .output_ready    (out_ready),
    .output_result   (out_result),
    .output_carry    (out_carry),
    .output_zero     (out_zero),
    .output_negative (out_negative),
    .output_inverted (out_inverted),
    .output_valid    (out_valid),
    .input_ready     (in_ready),
    .output_level    (out_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic inv, input logic c);
    in_valid  = v;
    in_data   = d;
    in_invert = inv;
    in_carry  = c;
  endtask

  initial begin
    rst      = 1'b1;
    in_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(out_level), 32'd0);
    check("rst_result", 32'(out_result), 32'h00);
    check("rst_flags", 32'({out_carry, out_zero, out_negative, out_inverted}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(out_ready), 32'd1);

    // negate path: ~8'h05 = 8'hFA, +1 -> 8'hFB
    drive(1'b1, 8'hFA, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("neg_valid", 32'(out_valid), 32'd1);
    check("neg_result", 32'(out_result), 32'hFB);
    check("neg_flags", 32'({out_carry, out_zero, out_negative, out_inverted}), 32'b0011);
    check("neg_level", 32'(out_level), 32'd1);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("neg_pop_valid", 32'(out_valid), 32'd0);
    check("neg_pop_result", 32'(out_result), 32'h00);

    // wrap/zero then positive
    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("wrap_level", 32'(out_level), 32'd2);
    check("wrap_ready", 32'(out_ready), 32'd0);
    check("wrap_result", 32'(out_result), 32'h00);
    check("wrap_flags", 32'({out_carry, out_zero, out_negative, out_inverted}), 32'b1100);
    in_ready = 1'b1;
    tick();
    check("pos_result", 32'(out_result), 32'h7F);
    check("pos_flags", 32'({out_carry, out_zero, out_negative, out_inverted}), 32'b0000);
    check("pos_level", 32'(out_level), 32'd1);
    tick();
    in_ready = 1'b0;
    check("wrap_empty", 32'(out_valid), 32'd0);

    // back-pressure: third beat held while full
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    check("bp_ready", 32'(out_ready), 32'd0);
    check("bp_level", 32'(out_level), 32'd2);
    check("bp_head", 32'(out_result), 32'h01);
    // full with simultaneous pop: pop happens, push refused
    in_ready = 1'b1;
    tick();
    check("fullpop_level", 32'(out_level), 32'd1);
    check("fullpop_head", 32'(out_result), 32'h02);
    check("fullpop_ready", 32'(out_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp_third_level", 32'(out_level), 32'd1);
    check("bp_third_head", 32'(out_result), 32'h03);
    tick();
    check("bp_drained", 32'(out_level), 32'd0);

    // streaming: one result per cycle, level stays 1, wraps through 8'hFF
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic       c;
      logic [8:0] sum;
      d   = 8'hF0 + 8'(i);
      c   = ((i % 3) == 0);
      sum = {1'b0, d} + {8'h00, c};
      drive(1'b1, d, 1'b0, c);
      exp_q.push_back(sum);
      check("stream_ready", 32'(out_ready), 32'd1);
      tick();
      check("stream_level", 32'(out_level), 32'd1);
      if (exp_q.size() == 0) begin
        check("stream_sb_empty", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("stream_data", 32'({out_carry, out_result}), 32'(e));
        check("stream_zero", 32'(out_zero), 32'(e[7:0] == 8'h00));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("stream_end_level", 32'(out_level), 32'd0);
    check("stream_sb_left", 32'(exp_q.size()), 32'd0);

    // mid-stream reset with level 2
    in_ready = 1'b0;
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h5A, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_level_pre", 32'(out_level), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(out_level), 32'd0);
    check("mid_rst_result", 32'(out_result), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(out_ready), 32'd1);
    drive(1'b1, 8'h10, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_level", 32'(out_level), 32'd1);
    check("post_rst_result", 32'(out_result), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
